// File: rtl/midi_rx_fifo.sv
// midi_rx_fifo
//   MIDI serial receiver (8N1, LSB first, idle high) feeding a small FIFO
//   with a valid/ready read port.
//
//   Line path: midi_in -> SYNC_STAGES-flop synchroniser -> s -> receive FSM.
//   The FSM validates the start bit at mid-bit. It samples the 8 data bits
//   and then the stop bit at CLKS_PER_BIT intervals.
//   - A good stop bit queues the byte for a push on the following cycle.
//   - A low stop bit pulses framing_err and parks the FSM in BREAK until
//     the line returns high.
//
//   Read handshake: rd_valid is high whenever the FIFO holds at least one
//   byte, and rd_data is the head byte. A byte is consumed on every cycle
//   where rd_valid && rd_ready. rd_ready may be high while rd_valid is low;
//   the pop is simply ignored.
//
//   Ports:
//     clk, rst         system clock, synchronous active-high reset
//     midi_in          raw asynchronous MIDI line
//     rd_data          FIFO head byte (0 while empty)
//     rd_valid         FIFO non-empty
//     rd_ready         consumer accepts head
//     framing_err      one-cycle pulse, stop bit sampled low
//     overflow         one-cycle pulse, received byte dropped (FIFO full)
//     overflow_sticky  set by any overflow, cleared by rst
//     level            FIFO occupancy 0..DEPTH
//     dbg_state        receive FSM state (IDLE=0 START=1 DATA=2 STOP=3 BREAK=4)
//
//   Parameter constraints: CLK_HZ/BAUD >= 4, DEPTH a power of 2 >= 2,
//   SYNC_STAGES >= 2.
module midi_rx_fifo #(
  parameter int CLK_HZ      = 50000000,
  parameter int BAUD        = 31250,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     midi_in,
  output logic [7:0]               rd_data,
  output logic                     rd_valid,
  input  logic                     rd_ready,
  output logic                     framing_err,
  output logic                     overflow,
  output logic                     overflow_sticky,
  output logic [$clog2(DEPTH):0]   level,
  output logic [2:0]               dbg_state
);

  localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  localparam logic [CW-1:0] LAST_CYC = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_CYC = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } state_t;

  // ---------------------------------------------------------------------
  // Input synchroniser. Resets to the idle (high) line level so a reset
  // never looks like a start edge.
  // ---------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], midi_in};
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  // ---------------------------------------------------------------------
  // Receive FSM
  // ---------------------------------------------------------------------
  state_t        state_q, state_d;
  logic [CW-1:0] cyc_q, cyc_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          stop_ok;
  logic          stop_bad;
  logic          push_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cyc_q   <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      push_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      // The byte is written one cycle after the stop sample. shreg_q is
      // untouched during that cycle, so it is written straight from there.
      push_q  <= stop_ok;
    end
  end

  always_comb begin
    state_d  = state_q;
    cyc_d    = cyc_q;
    bit_d    = bit_q;
    shreg_d  = shreg_q;
    stop_ok  = 1'b0;
    stop_bad = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!s) begin
          state_d = ST_START;
          cyc_d   = '0;
          bit_d   = '0;
        end
      end
      ST_START: begin
        // Mid-start-bit check rejects glitches shorter than half a bit.
        if (cyc_q == HALF_CYC) begin
          cyc_d   = '0;
          state_d = s ? ST_IDLE : ST_DATA;
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end
      ST_DATA: begin
        if (cyc_q == LAST_CYC) begin
          cyc_d          = '0;
          shreg_d[bit_q] = s;
          if (bit_q == 3'd7) begin
            state_d = ST_STOP;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end
      ST_STOP: begin
        if (cyc_q == LAST_CYC) begin
          cyc_d = '0;
          if (s) begin
            stop_ok = 1'b1;
            state_d = ST_IDLE;
          end else begin
            stop_bad = 1'b1;
            state_d  = ST_BREAK;
          end
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end
      ST_BREAK: begin
        // Hold off until the line is released, so a long low (break or
        // unplugged cable) produces exactly one framing error.
        if (s) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign framing_err = stop_bad;
  assign dbg_state   = state_q;

  // ---------------------------------------------------------------------
  // FIFO
  // ---------------------------------------------------------------------
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          pop;
  logic          full;
  logic          push_ok;

  assign rd_valid = (level != '0);
  assign pop      = rd_valid && rd_ready;
  assign full     = (level == FULL_LVL);
  // A pop in the same cycle frees the slot the push needs.
  assign push_ok  = push_q && (!full || pop);
  assign overflow = push_q && full && !pop;
  assign rd_data  = rd_valid ? mem[rd_ptr] : 8'h00;

  // Storage is not reset; rd_data is gated while empty.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= shreg_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      level           <= '0;
      overflow_sticky <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push_ok && !pop) begin
        level <= level + 1'b1;
      end else if (!push_ok && pop) begin
        level <= level - 1'b1;
      end
      if (overflow) begin
        overflow_sticky <= 1'b1;
      end
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(framing_err && overflow));
      assert (level <= FULL_LVL);
    end
  end
`endif

endmodule

// File: tb/tb_midi_rx_fifo.sv
module tb_midi_rx_fifo;

  localparam int CPB = 16;

  logic       clk;
  logic       rst;
  logic       midi_in;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       rd_ready;
  logic       framing_err;
  logic       overflow;
  logic       overflow_sticky;
  logic [2:0] level;
  logic [2:0] dbg_state;

  midi_rx_fifo #(
    .CLK_HZ      (500000),
    .BAUD        (31250),
    .DEPTH       (4),
    .SYNC_STAGES (2)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .midi_in         (midi_in),
    .rd_data         (rd_data),
    .rd_valid        (rd_valid),
    .rd_ready        (rd_ready),
    .framing_err     (framing_err),
    .overflow        (overflow),
    .overflow_sticky (overflow_sticky),
    .level           (level),
    .dbg_state       (dbg_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [7:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int valid_cycles = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  always @(negedge clk) begin
    logic [7:0] e;
    if (rd_valid) valid_cycles++;
    if (framing_err) fe_cnt++;
    if (overflow) ov_cnt++;
    if (rd_valid && rd_ready) begin
      check("rd_queue_nonempty", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("rd_data", 32'(rd_data), 32'(e));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_bit(input logic b);
    midi_in = b;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  // One 8N1 frame; the expected byte is queued when the bench expects the
  // FIFO to accept it.
  task automatic send_byte(input logic [7:0] d, input logic stop, input logic expect_it);
    @(posedge clk);
    #1;
    if (expect_it) exp_q.push_back(d);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(stop);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------- test sequence ----------------
  int fe0;
  int ov0;
  logic [7:0] fill [4];

  initial begin
    fill[0] = 8'h90; fill[1] = 8'h3C; fill[2] = 8'h64; fill[3] = 8'h80;
    rst = 1'b1;
    midi_in = 1'b1;
    rd_ready = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst = 1'b0;

    // Reset values
    check("rst_rd_valid", 32'(rd_valid), 32'd0);
    check("rst_rd_data", 32'(rd_data), 32'd0);
    check("rst_framing_err", 32'(framing_err), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_sticky", 32'(overflow_sticky), 32'd0);
    check("rst_level", 32'(level), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    idle(5);

    // 1: single byte with consumer ready
    rd_ready = 1'b1;
    valid_cycles = 0;
    send_byte(8'h90, 1'b1, 1'b1);
    idle(10);
    check("t1_valid_cycles", 32'(valid_cycles), 32'd1);
    check("t1_level", 32'(level), 32'd0);
    check("t1_drained", 32'(exp_q.size()), 32'd0);
    check("t1_fe_cnt", 32'(fe_cnt), 32'd0);
    check("t1_ov_cnt", 32'(ov_cnt), 32'd0);

    // 2: 4-cycle glitch is rejected, then a real frame decodes
    valid_cycles = 0;
    @(posedge clk); #1 midi_in = 1'b0;
    idle(4);
    midi_in = 1'b1;
    idle(20);
    check("t2_state_idle", 32'(dbg_state), 32'd0);
    check("t2_no_byte", 32'(valid_cycles), 32'd0);
    check("t2_fe_cnt", 32'(fe_cnt), 32'd0);
    send_byte(8'h3C, 1'b1, 1'b1);
    idle(10);
    check("t2_drained", 32'(exp_q.size()), 32'd0);

    // 3: framing error followed by a held-low line
    fe0 = fe_cnt;
    valid_cycles = 0;
    send_byte(8'h45, 1'b0, 1'b0);
    idle(40);
    check("t3_state_break", 32'(dbg_state), 32'd4);
    check("t3_fe_pulse", 32'(fe_cnt - fe0), 32'd1);
    check("t3_level", 32'(level), 32'd0);
    midi_in = 1'b1;
    idle(10);
    check("t3_state_idle", 32'(dbg_state), 32'd0);
    check("t3_no_byte", 32'(valid_cycles), 32'd0);
    send_byte(8'h7F, 1'b1, 1'b1);
    idle(10);
    check("t3_drained", 32'(exp_q.size()), 32'd0);
    check("t3_fe_once", 32'(fe_cnt - fe0), 32'd1);

    // 4: overflow on the fifth byte while the consumer stalls
    rd_ready = 1'b0;
    ov0 = ov_cnt;
    for (int i = 0; i < 4; i++) send_byte(fill[i], 1'b1, 1'b1);
    send_byte(8'h40, 1'b1, 1'b0);
    idle(5);
    check("t4_level_full", 32'(level), 32'd4);
    check("t4_ov_pulse", 32'(ov_cnt - ov0), 32'd1);
    check("t4_sticky", 32'(overflow_sticky), 32'd1);
    check("t4_head", 32'(rd_data), 32'h90);
    rd_ready = 1'b1;
    idle(8);
    check("t4_drained", 32'(exp_q.size()), 32'd0);
    check("t4_level_empty", 32'(level), 32'd0);

    // 5: full FIFO, pop on the exact push cycle of a fifth byte
    rd_ready = 1'b0;
    ov0 = ov_cnt;
    for (int i = 0; i < 4; i++) send_byte(fill[i], 1'b1, 1'b1);
    fork
      send_byte(8'h11, 1'b1, 1'b1);
      begin
        // Stop sample lands 155 edges after the start is driven; the push
        // cycle is the one that follows.
        @(posedge clk);
        repeat (155) @(posedge clk);
        #1 rd_ready = 1'b1;
        @(posedge clk);
        #1 rd_ready = 1'b0;
      end
    join
    idle(5);
    check("t5_no_overflow", 32'(ov_cnt - ov0), 32'd0);
    check("t5_level_full", 32'(level), 32'd4);
    rd_ready = 1'b1;
    idle(8);
    check("t5_drained", 32'(exp_q.size()), 32'd0);
    check("t5_level_empty", 32'(level), 32'd0);
    check("t5_sticky_held", 32'(overflow_sticky), 32'd1);

    // 6: reset during data bit 4, with a byte parked in the FIFO
    rd_ready = 1'b0;
    send_byte(8'h22, 1'b1, 1'b1);
    idle(3);
    check("t6_level_pre", 32'(level), 32'd1);
    @(posedge clk); #1;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'b0 ^ (i == 3));
    midi_in = 1'b1;
    idle(8);
    check("t6_state_data", 32'(dbg_state), 32'd2);
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    check("t6_rd_valid", 32'(rd_valid), 32'd0);
    check("t6_rd_data", 32'(rd_data), 32'd0);
    check("t6_level", 32'(level), 32'd0);
    check("t6_sticky", 32'(overflow_sticky), 32'd0);
    check("t6_framing_err", 32'(framing_err), 32'd0);
    check("t6_overflow", 32'(overflow), 32'd0);
    check("t6_state", 32'(dbg_state), 32'd0);
    idle(20);
    rd_ready = 1'b1;
    send_byte(8'hF8, 1'b1, 1'b1);
    idle(10);
    check("t6_drained", 32'(exp_q.size()), 32'd0);
    check("t6_level_end", 32'(level), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/midi_rx_fifo.md
Name: midi_rx_fifo

Overview:
Parametrised MIDI serial receiver with an output FIFO. It converts the asynchronous MIDI line (8N1, LSB first, idle high) into bytes and adds start-bit validation, framing-error detection, and a valid/ready read port backed by a DEPTH-entry FIFO with overflow reporting. It sits between the MIDI input pin and the downstream MIDI message parser.

Parameters:
CLK_HZ, 50000000, system clock frequency in Hz.
BAUD, 31250, line bit rate. CLKS_PER_BIT = CLK_HZ/BAUD (integer division, must be >= 4).
DEPTH, 4, FIFO entries. Must be a power of 2, >= 2.
SYNC_STAGES, 2, flip-flops in the midi_in synchroniser. Must be >= 2.

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
midi_in  in  1  raw asynchronous MIDI line, idle high
rd_data  out  8  byte at the FIFO head
rd_valid  out  1  FIFO non-empty
rd_ready  in  1  consumer accepts the head when rd_valid && rd_ready
framing_err  out  1  one-cycle pulse: stop bit sampled low
overflow  out  1  one-cycle pulse: a complete byte was dropped because the FIFO was full
overflow_sticky  out  1  set by any overflow, cleared only by rst
level  out  $clog2(DEPTH)+1  current FIFO occupancy, 0..DEPTH

Behaviour:
- Reset is synchronous: state=IDLE, counters=0, FIFO empty. Outputs after reset: rd_valid=0, rd_data=0, framing_err=0, overflow=0, overflow_sticky=0, level=0. The synchroniser flops reset to 1.
- Reset mid-frame abandons the partial byte. FIFO contents are lost.
- All line decisions use the synchronised signal `s`, which is midi_in delayed by SYNC_STAGES cycles.
- FSM states: IDLE, START, DATA, STOP, BREAK.
- IDLE: on s==0, go to START, bit counter=0, cycle counter=0.
- START: at count CLKS_PER_BIT/2-1, sample s.
  - s==1: false start (glitch). Return to IDLE with no output.
  - s==0: go to DATA, cycle counter=0.
- DATA: sample s every CLKS_PER_BIT cycles (mid-bit). Shift into bit[bit_cnt], LSB first. After the 8th sample, go to STOP.
- STOP: sample s after CLKS_PER_BIT cycles.
  - s==1: push the byte and go to IDLE (the next start can be detected on the following cycle).
  - s==0: pulse framing_err, discard the byte, go to BREAK.
- BREAK: stay until s==1, then go to IDLE.
- Push timing: the byte is written on the cycle after the stop sample. rd_valid rises on the cycle after the write, so it is visible 2 cycles after the stop-bit sample.
- FIFO:
  - Circular buffer; pointers wrap modulo DEPTH.
  - rd_data is the head entry; rd_data=0 when empty is not required after the first write.
  - Pop occurs when rd_valid && rd_ready.
  - A push is accepted when level<DEPTH, or when a pop occurs in the same cycle. Simultaneous push+pop leaves level unchanged.
  - A push to a full FIFO with no pop drops the byte, pulses overflow for 1 cycle and sets overflow_sticky. Existing contents are untouched.
  - A pop while empty is ignored.
- framing_err and overflow are never high on the same cycle: framing_err is driven in STOP, overflow on the push cycle.
- The counter is wide enough for CLKS_PER_BIT-1. No drift correction is applied; resynchronisation happens on each start edge.

Test Plan:
All scenarios use CLK_HZ=500000, BAUD=31250 (CLKS_PER_BIT=16), DEPTH=4.
- Send 0x90 (line: 0,0,0,0,0,1,0,0,1,1) with rd_ready=1 -> rd_valid for exactly 1 cycle with rd_data=0x90, level returns to 0, no error pulses.
- Drive midi_in low for 4 cycles from idle -> no byte, framing_err=0, FSM back in IDLE. A following 0x3C frame then decodes correctly.
- Send 0x45 with stop bit low, then hold the line low for 40 cycles, then high -> single framing_err pulse, level stays 0, no byte until the line returns high. A next 0x7F frame is received.
- With rd_ready=0, send 0x90,0x3C,0x64,0x80,0x40 back to back -> level=4, one overflow pulse on the 5th byte, overflow_sticky=1. Then rd_ready=1 reads 0x90,0x3C,0x64,0x80 in order.
- With FIFO full and rd_ready asserted on the push cycle of a 5th byte 0x11 -> no overflow, level stays 4, and 0x11 is read last.
- Assert rst during DATA bit 4 of a frame -> all outputs take reset values next cycle, level=0, overflow_sticky=0. A subsequent 0xF8 frame is received correctly.
